fifo_rd_prefetch: RTL and testbench
===================================

# fifo_rd_prefetch

Read-side prefetch adapter that sits between the read port of a standard (non-FWFT) synchronous FIFO, which has one-cycle read latency from its SRAM, and a valid/ready consumer. It issues FIFO reads ahead of demand, holds up to two words in a register buffer, and presents first-word-fall-through data. Back-to-back reads sustain one word per cycle. It is the consumer-side counterpart of the FIFO write path and makes a plain SRAM FIFO usable wherever `fifo_fwft` semantics are expected.

## Interface
- `DATA_WIDTH`, 8, width of a data word
- `clk`  in  1  clock; all logic on posedge
- `rst_n`  in  1  reset, synchronous, active-low
- `flush_i`  in  1  discard all buffered and in-flight words
- `fifo_empty_i`  in  1  upstream FIFO empty flag
- `fifo_ren_o`  out  1  upstream read strobe
- `fifo_rdata_i`  in  DATA_WIDTH  upstream read data, valid exactly 1 cycle after `fifo_ren_o`
- `rvalid_o`  out  1  head word available
- `rready_i`  in  1  consumer accepts head word
- `rdata_o`  out  DATA_WIDTH  head word
- `count_o`  out  2  words held in buffer (0..2), excluding in-flight

## Operation
- State:
  - occupancy `occ` is 0, 1 or 2, encoded EMPTY/ONE/TWO.
  - `inflight_q` is a 1-bit flag that is set the cycle after `fifo_ren_o`.
  - The buffer is a 2-entry register store with a head pointer.
- `pop = rvalid_o && rready_i`.
- Read issue: `fifo_ren_o = rst_n && !flush_i && !fifo_empty_i && (occ + inflight_q - pop) < 2`.
  - `rready_i` therefore has a combinational path to `fifo_ren_o`. This is intentional and required for full throughput.
- Capture: when `inflight_q` is set, write `fifo_rdata_i` into the tail entry.
- Occupancy update:
  - `occ_next = occ + inflight_q - pop`.
  - If the buffer is EMPTY, capture and pop cannot happen in the same cycle, because `rvalid_o` is 0.
- Transitions:
  - EMPTY→ONE on capture.
  - ONE→TWO on capture without pop.
  - ONE→EMPTY on pop without capture.
  - ONE→ONE on capture with pop.
  - TWO→ONE on pop (capture is impossible in TWO).
  - TWO→TWO otherwise.
- Outputs:
  - `rvalid_o = (occ != EMPTY)`.
  - `rdata_o` = head entry.
  - `count_o = occ`.
- Consumer rule: while `rvalid_o && !rready_i`, `rdata_o` holds stable.
- Ordering: words leave in exactly the order they were read from the FIFO. No duplication, no loss except on flush.
- Flush (priority over all but reset):
  - Next cycle `occ` = EMPTY and the head pointer = 0.
  - `fifo_ren_o` is 0 during the flush cycle.
  - A word in flight during the flush cycle is dropped: `inflight_q` is cleared and no capture happens.
- Reset (`rst_n` low at posedge), including mid-transfer:
  - `occ` = EMPTY, `inflight_q` = 0, head = 0, both entries = 0.
  - While `rst_n` is low, `fifo_ren_o` = 0.
  - Reset values: `rvalid_o` 0, `rdata_o` 0, `count_o` 0, `fifo_ren_o` 0.
- Upstream contract: never assert `fifo_ren_o` while `fifo_empty_i` is 1. The FIFO's own count/empty update is the FIFO's responsibility.

## Timing
- Fall-through latency:
  - Cycle 0: `fifo_empty_i` falls and `occ + inflight_q` = 0, so `fifo_ren_o` = 1.
  - Cycle 1: data on `fifo_rdata_i`.
  - Cycle 2: `rvalid_o` = 1 with that word.
- Throughput:
  - Steady state is `occ` = 1 and `inflight_q` = 1 with `rready_i` held at 1.
  - This gives `fifo_ren_o` = 1 and `rvalid_o` = 1 every cycle, i.e. 1 word/cycle.
- Backpressure:
  - With `rready_i` = 0, at most 2 words are captured and `fifo_ren_o` then stays 0.
  - Total fetched never exceeds 2 plus pops.
- Deassertion of `rready_i` for 1 cycle mid-stream produces no bubble once `rready_i` returns, provided the FIFO is non-empty.

## Structure
- Shared package `fifo_pkg`:
  - enum `occ_e` {EMPTY, ONE, TWO}
  - constant `PREFETCH_DEPTH` = 2
- Sub-module `fifo_rd_skid2`:
  - 2-entry register buffer with head/tail pointer.
  - Ports: push, push data, pop, head data, occupancy.
- The top level holds the issue logic, `inflight_q` and flush.

## Test plan
- Reset then idle:
  - Stimulus: `fifo_empty_i` = 1, `rst_n` = 0 for 2 cycles, then 1.
  - Required: `rvalid_o` = 0, `rdata_o` = 0, `count_o` = 0, `fifo_ren_o` = 0 throughout.
- Single word:
  - Stimulus: FIFO holds {0x11}, `rready_i` = 0.
  - Required: `fifo_ren_o` pulses once; `rvalid_o` = 1 with 0x11 two cycles later and stays stable. `rready_i` = 1 then pops it, and `rvalid_o` = 0 next cycle.
- Streaming:
  - Stimulus: FIFO preloaded with 1..10, `rready_i` = 1 continuously.
  - Required: `rdata_o` = 1,2,…,10 on 10 consecutive cycles starting 2 cycles after the first read; no gaps.
- Backpressure:
  - Stimulus: FIFO holds 1..6, `rready_i` = 0 for 5 cycles.
  - Required: exactly 2 reads issued and `count_o` = 2. Release to 1/0/1/1 yields 1,2,3,4 in order with no drop or duplicate.
- Flush with in-flight word:
  - Stimulus: assert `flush_i` in the cycle after `fifo_ren_o` while `occ` = 1.
  - Required: next cycle `count_o` = 0, `rvalid_o` = 0, and the in-flight word is never presented. The following FIFO word is delivered normally.
- Reset mid-stream:
  - Stimulus: `rst_n` = 0 for 1 cycle during test 3, while `occ` = 1 and `inflight_q` = 1.
  - Required: all outputs return to reset values on the next cycle; no capture of the in-flight data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side prefetch adapter.
//   occ_e          : buffer occupancy state (EMPTY/ONE/TWO)
//   PREFETCH_DEPTH : number of words the prefetch buffer can hold
//   occ_count      : converts an occupancy state into a 2-bit word count
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam int unsigned PREFETCH_DEPTH = 2;

  function automatic logic [1:0] occ_count(input occ_e occ);
    logic [1:0] cnt;
    case (occ)
      EMPTY:   cnt = 2'd0;
      ONE:     cnt = 2'd1;
      TWO:     cnt = 2'd2;
      default: cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/fifo_rd_skid2.sv
// Two-entry register buffer with head pointer; the tail is derived from the
// head and the occupancy.
//   clk, rst_n   : clock, synchronous active-low reset
//   clr_i        : empties the buffer and rewinds the head (no write this cycle)
//   push_i       : write push_data_i into the tail entry
//   pop_i        : consume the head entry
//   head_data_o  : current head entry
//   occ_o        : occupancy state
module fifo_rd_skid2
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output occ_e                  occ_o
);

  occ_e                                          occ_q, occ_d;
  logic                                          head_q, head_d;
  logic [PREFETCH_DEPTH-1:0][DATA_WIDTH-1:0]     mem_q;
  logic                                          tail_s;
  logic                                          push_s;
  logic                                          pop_s;

  // A push into a full buffer or a pop from an empty one is ignored so a
  // misbehaving caller cannot corrupt the occupancy.
  assign push_s = push_i && (occ_q != TWO);
  assign pop_s  = pop_i && (occ_q != EMPTY);

  // With one word held the free slot is the one after the head; otherwise
  // (empty) the next write lands at the head itself.
  assign tail_s = head_q ^ (occ_q == ONE);

  // Next occupancy and head pointer.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    if (clr_i) begin
      occ_d  = EMPTY;
      head_d = 1'b0;
    end else begin
      if (pop_s) begin
        head_d = ~head_q;
      end else begin
        head_d = head_q;
      end
      case (occ_q)
        EMPTY: begin
          if (push_s) occ_d = ONE;
          else        occ_d = EMPTY;
        end
        ONE: begin
          if (push_s && !pop_s)      occ_d = TWO;
          else if (!push_s && pop_s) occ_d = EMPTY;
          else                       occ_d = ONE;
        end
        TWO: begin
          if (pop_s) occ_d = ONE;
          else       occ_d = TWO;
        end
        default: occ_d = EMPTY;
      endcase
    end
  end

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q  <= EMPTY;
      head_q <= 1'b0;
      mem_q  <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      if (push_s && !clr_i) begin
        mem_q[tail_s] <= push_data_i;
      end
    end
  end

  assign head_data_o = mem_q[head_q];
  assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_rd_prefetch.sv
// Read-side prefetch adapter: turns a one-cycle-latency FIFO read port into a
// first-word-fall-through valid/ready stream, sustaining one word per cycle.
//   clk, rst_n    : clock, synchronous active-low reset
//   flush_i       : drop all buffered and in-flight words
//   fifo_empty_i  : upstream FIFO empty
//   fifo_ren_o    : upstream read strobe
//   fifo_rdata_i  : upstream data, valid one cycle after fifo_ren_o
//   rvalid_o      : head word available
//   rready_i      : consumer takes the head word
//   rdata_o       : head word
//   count_o       : words held in the buffer (in-flight word excluded)
module fifo_rd_prefetch
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_ren_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            count_o
);

  occ_e       occ_s;
  logic [1:0] occ_cnt_s;
  logic       inflight_q, inflight_d;
  logic       pop_s;
  logic       capture_s;
  logic [2:0] need_s;
  logic       ren_s;

  assign occ_cnt_s = occ_count(occ_s);
  assign rvalid_o  = (occ_s != EMPTY);
  assign count_o   = occ_cnt_s;
  assign pop_s     = rvalid_o && rready_i;

  // Words that will be held next cycle if no new read is issued. A pop only
  // happens with occ >= 1, so this never underflows.
  assign need_s = {1'b0, occ_cnt_s} + {2'b00, inflight_q} - {2'b00, pop_s};

  // Issue a read only if its word is guaranteed a slot on arrival; the pop
  // term gives rready_i a combinational path here, which is what lets the
  // stream run at one word per cycle.
  assign ren_s      = rst_n && !flush_i && !fifo_empty_i &&
                      (need_s < 3'(PREFETCH_DEPTH));
  assign fifo_ren_o = ren_s;

  // A word in flight during a flush is simply not captured.
  assign capture_s  = inflight_q && !flush_i;
  assign inflight_d = ren_s;

  // In-flight flag: the upstream read data is valid the cycle after the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  fifo_rd_skid2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (flush_i),
    .push_i      (capture_s),
    .push_data_i (fifo_rdata_i),
    .pop_i       (pop_s),
    .head_data_o (rdata_o),
    .occ_o       (occ_s)
  );

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Self-checking bench for fifo_rd_prefetch: a behavioural FIFO feeds the DUT
// and a queue-based reference model of the prefetch buffer predicts every
// output each cycle.
module tb_fifo_rd_prefetch;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_i;
  logic          fifo_empty_i;
  logic          fifo_ren_o;
  logic [DW-1:0] fifo_rdata_i = '0;
  logic          rvalid_o;
  logic          rready_i;
  logic [DW-1:0] rdata_o;
  logic [1:0]    count_o;

  fifo_rd_prefetch #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_ren_o   (fifo_ren_o),
    .fifo_rdata_i (fifo_rdata_i),
    .rvalid_o     (rvalid_o),
    .rready_i     (rready_i),
    .rdata_o      (rdata_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  // Behavioural upstream FIFO with one-cycle read latency.
  logic [7:0] fmem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  assign fifo_empty_i = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_ren_o === 1'b1 && wr_ptr != rd_ptr) begin
      fifo_rdata_i <= fmem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Counters and reference model state.
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_ren    = 0;
  int         n_pop    = 0;
  logic [7:0] last_pop = 8'd0;
  logic [7:0] m_buf [$];
  bit         m_infl = 1'b0;
  logic [7:0] m_infl_word = 8'd0;
  bit         m_zero = 1'b1;
  bit         chk_en = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Per-cycle check and model advance at the falling edge; inputs are stable
  // from here to the next rising edge, so the model sees what the DUT will.
  always @(negedge clk) begin
    if (chk_en) begin
      int occ;
      bit pop;
      bit exp_ren;
      occ     = m_buf.size();
      pop     = (occ > 0) && (rready_i === 1'b1);
      exp_ren = (rst_n === 1'b1) && (flush_i === 1'b0) && (wr_ptr != rd_ptr) &&
                ((occ + int'(m_infl) - int'(pop)) < 2);
      check_eq("rvalid", 32'(rvalid_o), 32'(occ > 0));
      check_eq("count", 32'(count_o), 32'(occ));
      if (occ > 0) check_eq("rdata", 32'(rdata_o), 32'(m_buf[0]));
      else if (m_zero) check_eq("rdata_rst", 32'(rdata_o), 32'd0);
      check_eq("ren", 32'(fifo_ren_o), 32'(exp_ren));
      if (fifo_ren_o === 1'b1) n_ren++;
      if (rvalid_o === 1'b1 && rready_i === 1'b1) begin
        n_pop++;
        last_pop = rdata_o;
      end
      if (rst_n !== 1'b1) begin
        m_buf.delete();
        m_infl = 1'b0;
        m_zero = 1'b1;
      end else if (flush_i === 1'b1) begin
        m_buf.delete();
        m_infl = 1'b0;
      end else begin
        if (pop) void'(m_buf.pop_front());
        if (m_infl) begin
          m_buf.push_back(m_infl_word);
          m_zero = 1'b0;
        end
        m_infl = exp_ren;
        if (exp_ren) m_infl_word = fmem[rd_ptr];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    fmem[wr_ptr] = v;
    wr_ptr++;
  endtask

  initial begin
    int ren0;
    int pop0;
    rst_n    = 1'b0;
    flush_i  = 1'b0;
    rready_i = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;

    // Reset then idle.
    step(1);
    rst_n = 1'b1;
    step(3);
    check_eq("idle_ren_cnt", 32'(n_ren), 32'd0);

    // Single word held under backpressure, then popped.
    ren0 = n_ren;
    push(8'h11);
    step(4);
    check_eq("single_rdata", 32'(rdata_o), 32'h11);
    check_eq("single_count", 32'(count_o), 32'd1);
    check_eq("single_ren_cnt", 32'(n_ren - ren0), 32'd1);
    rready_i = 1'b1;
    step(1);
    rready_i = 1'b0;
    check_eq("single_gone", 32'(rvalid_o), 32'd0);
    step(1);

    // Streaming 1..10.
    pop0 = n_pop;
    for (int i = 1; i <= 10; i++) push(8'(i));
    rready_i = 1'b1;
    step(12);
    check_eq("stream_pops", 32'(n_pop - pop0), 32'd10);
    check_eq("stream_last", 32'(last_pop), 32'd10);
    step(2);

    // Backpressure: only two reads while stalled, then 1/0/1/1 release.
    rready_i = 1'b0;
    ren0 = n_ren;
    for (int i = 1; i <= 6; i++) push(8'(i));
    step(5);
    check_eq("bp_ren_cnt", 32'(n_ren - ren0), 32'd2);
    check_eq("bp_count", 32'(count_o), 32'd2);
    rready_i = 1'b1; step(1);
    rready_i = 1'b0; step(1);
    rready_i = 1'b1; step(2);
    check_eq("bp_last", 32'(last_pop), 32'd3);
    step(10);
    check_eq("bp_drained", 32'(rvalid_o), 32'd0);

    // Flush while one word is held and another is in flight.
    rready_i = 1'b0;
    pop0 = n_pop;
    push(8'hA0); push(8'hA1); push(8'hA2);
    step(2);
    check_eq("flush_pre_count", 32'(count_o), 32'd1);
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    check_eq("flush_count", 32'(count_o), 32'd0);
    check_eq("flush_rvalid", 32'(rvalid_o), 32'd0);
    rready_i = 1'b1;
    step(6);
    check_eq("flush_pops", 32'(n_pop - pop0), 32'd1);
    check_eq("flush_next_word", 32'(last_pop), 32'hA2);

    // Reset during steady-state streaming.
    for (int i = 1; i <= 10; i++) push(8'(8'h40 + i));
    step(4);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check_eq("rst_mid_rvalid", 32'(rvalid_o), 32'd0);
    check_eq("rst_mid_count", 32'(count_o), 32'd0);
    check_eq("rst_mid_rdata", 32'(rdata_o), 32'd0);
    step(16);
    check_eq("rst_mid_last", 32'(last_pop), 32'h4A);

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 600; c++) begin
      rready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) push(8'($urandom));
      flush_i = ($urandom_range(0, 24) == 0);
      rst_n   = ($urandom_range(0, 96) != 0);
      step(1);
    end
    flush_i  = 1'b0;
    rst_n    = 1'b1;
    rready_i = 1'b1;
    step(700);
    check_eq("rand_fifo_drained", 32'(fifo_empty_i), 32'd1);
    check_eq("rand_buf_drained", 32'(rvalid_o), 32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
